// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding, time limits and counter sizing
// for the alarm unit.
package alarm_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        ARMED  = 2'd1,
        RING   = 2'd2,
        SNOOZE = 2'd3
    } state_e;

    localparam int MAX_HOUR    = 23;
    localparam int MAX_MIN     = 59;
    localparam int SEC_PER_MIN = 60;

    // Bits needed to count the seconds of a snooze of `minutes` minutes.
    function automatic int snz_cnt_w(input int minutes);
        return $clog2(minutes * SEC_PER_MIN);
    endfunction

endpackage

// File: rtl/alarm_if.sv
// alarm_if: time inputs, alarm controls and indicator outputs of
// the alarm unit, grouped for the driver (master) and unit (slave).
interface alarm_if;
    logic       SecTick;
    logic [4:0] Hour;
    logic [5:0] Minute;
    logic [5:0] Second;
    logic [4:0] SetHour;
    logic [5:0] SetMin;
    logic       SetLoad;
    logic       Arm;
    logic       SnoozeReq;
    logic       StopReq;
    logic       Ring;
    logic       LedBlink;
    logic       Armed;
    logic       Snoozing;
    logic [4:0] AlarmHour;
    logic [5:0] AlarmMin;

    modport master (
        output SecTick, Hour, Minute, Second,
        output SetHour, SetMin, SetLoad,
        output Arm, SnoozeReq, StopReq,
        input  Ring, LedBlink, Armed, Snoozing,
        input  AlarmHour, AlarmMin
    );

    modport slave (
        input  SecTick, Hour, Minute, Second,
        input  SetHour, SetMin, SetLoad,
        input  Arm, SnoozeReq, StopReq,
        output Ring, LedBlink, Armed, Snoozing,
        output AlarmHour, AlarmMin
    );
endinterface

// File: rtl/alarm_unit_tick.sv
// tick_counter: counts enabled ticks from a clear and flags when the
// count sits at its terminal value.
module tick_counter #(
    parameter int W    = 8,
    parameter int TERM = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);
    localparam logic [W-1:0] TERM_V = W'(TERM);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == TERM_V);
endmodule

// File: rtl/alarm_unit.sv
// alarm_unit: programmable alarm with arm/ring/snooze sequencing,
// fed by the RTC time counters and per-second strobe.
module alarm_unit
    import alarm_pkg::*;
#(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int SNOOZE_MAX = 3
) (
    input  logic   Clk50,
    input  logic   Reset,
    alarm_if.slave bus
);
    localparam int         SNZ_W    = snz_cnt_w(MAX_MIN);
    localparam logic [2:0] USED_MAX = 3'(SNOOZE_MAX);

    state_e     state_q, state_d;
    logic       match, match_q, trigger, load_ok;
    logic [4:0] ahour_q, ahour_d;
    logic [5:0] amin_q, amin_d;
    logic [2:0] used_q, used_d;
    logic       ring_clr, ring_en, ring_term;
    logic       snz_clr, snz_en, snz_term;
    logic       ring_q, ring_d, blink_q, blink_d;
    logic       armed_q, armed_d, snzo_q, snzo_d;

    assign match = (bus.Hour == ahour_q) && (bus.Minute == amin_q)
                && (bus.Second == 6'd0);
    assign trigger = match && !match_q;
    assign load_ok = bus.SetLoad
                  && (bus.SetHour <= 5'(MAX_HOUR))
                  && (bus.SetMin <= 6'(MAX_MIN));
    assign ring_en = bus.SecTick && (state_q == RING);
    assign snz_en  = bus.SecTick && (state_q == SNOOZE);

    always_comb begin
        state_d  = state_q;
        used_d   = used_q;
        ring_clr = 1'b0;
        snz_clr  = 1'b0;
        if (!bus.Arm) begin
            state_d  = OFF;
            used_d   = '0;
            ring_clr = 1'b1;
            snz_clr  = 1'b1;
        end else begin
            unique case (state_q)
                OFF: state_d = ARMED;
                ARMED: begin
                    if (trigger) begin
                        state_d  = RING;
                        ring_clr = 1'b1;
                        used_d   = '0;
                    end
                end
                RING: begin
                    if (bus.StopReq) begin
                        state_d = ARMED;
                        used_d  = '0;
                    end else if (bus.SnoozeReq && used_q < USED_MAX) begin
                        state_d = SNOOZE;
                        used_d  = used_q + 3'd1;
                        snz_clr = 1'b1;
                    end else if (bus.SecTick && ring_term) begin
                        state_d = ARMED;
                        used_d  = '0;
                    end
                end
                SNOOZE: begin
                    if (bus.StopReq) begin
                        state_d = ARMED;
                        used_d  = '0;
                    end else if (bus.SecTick && snz_term) begin
                        state_d  = RING;
                        ring_clr = 1'b1;
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    // Disarming blanks the indicators on the very next edge.
    always_comb begin
        ahour_d = load_ok ? bus.SetHour : ahour_q;
        amin_d  = load_ok ? bus.SetMin : amin_q;
        ring_d  = bus.Arm && (state_q == RING);
        armed_d = bus.Arm && (state_q != OFF);
        snzo_d  = bus.Arm && (state_q == SNOOZE);
        blink_d = 1'b0;
        if (ring_d) begin
            blink_d = ring_q ? (blink_q ^ bus.SecTick) : 1'b1;
        end
    end

    always_ff @(posedge Clk50) begin
        if (Reset) begin
            state_q <= OFF;
            match_q <= 1'b1;
            ahour_q <= '0;
            amin_q  <= '0;
            used_q  <= '0;
            ring_q  <= 1'b0;
            blink_q <= 1'b0;
            armed_q <= 1'b0;
            snzo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match;
            ahour_q <= ahour_d;
            amin_q  <= amin_d;
            used_q  <= used_d;
            ring_q  <= ring_d;
            blink_q <= blink_d;
            armed_q <= armed_d;
            snzo_q  <= snzo_d;
        end
    end

    tick_counter #(
        .W    (8),
        .TERM (RING_SEC - 1)
    ) u_ring_cnt (
        .clk_i  (Clk50),
        .rst_i  (Reset),
        .clr_i  (ring_clr),
        .en_i   (ring_en),
        .term_o (ring_term)
    );

    tick_counter #(
        .W    (SNZ_W),
        .TERM (SNOOZE_MIN * SEC_PER_MIN - 1)
    ) u_snz_cnt (
        .clk_i  (Clk50),
        .rst_i  (Reset),
        .clr_i  (snz_clr),
        .en_i   (snz_en),
        .term_o (snz_term)
    );

    assign bus.Ring      = ring_q;
    assign bus.LedBlink  = blink_q;
    assign bus.Armed     = armed_q;
    assign bus.Snoozing  = snzo_q;
    assign bus.AlarmHour = ahour_q;
    assign bus.AlarmMin  = amin_q;
endmodule

// File: tb/tb_alarm_unit.sv
// tb_alarm_unit: scenario tasks plus randomized traffic, checked each
// cycle against a behavioural alarm model.
module tb_alarm_unit;
    localparam int RS = 4;
    localparam int SM = 1;
    localparam int SX = 2;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    alarm_if bus();

    alarm_unit #(
        .RING_SEC   (RS),
        .SNOOZE_MIN (SM),
        .SNOOZE_MAX (SX)
    ) dut (
        .Clk50 (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int phase = 0;
    int th = 0, tm = 0, ts = 0;

    // model: 0 off, 1 armed, 2 ringing, 3 snoozing
    int m_st = 0, m_used = 0, m_rt = 0, m_snt = 0, m_bt = 0;
    int m_ah = 0, m_am = 0;
    bit m_mprev = 1'b1;

    logic [14:0] exp_v = '0;
    logic [14:0] obs;
    assign obs = {bus.Ring, bus.LedBlink, bus.Armed, bus.Snoozing,
                  bus.AlarmHour, bus.AlarmMin};

    task automatic model_step();
        bit tick, match, trig, on;
        int os;
        tick = bus.SecTick;
        if (Reset) begin
            m_st = 0; m_used = 0; m_rt = 0; m_snt = 0; m_bt = 0;
            m_ah = 0; m_am = 0; m_mprev = 1'b1;
            exp_v = '0;
            return;
        end
        match = (bus.Hour == m_ah) && (bus.Minute == m_am)
             && (bus.Second == 0);
        trig = match && !m_mprev;
        m_mprev = match;
        os = m_st;
        if (os == 2 && tick) m_bt++;
        if (bus.SetLoad && bus.SetHour <= 23 && bus.SetMin <= 59) begin
            m_ah = int'(bus.SetHour);
            m_am = int'(bus.SetMin);
        end
        if (!bus.Arm) begin
            m_st = 0; m_used = 0;
        end else begin
            case (os)
                0: m_st = 1;
                1: if (trig) begin
                    m_st = 2; m_used = 0; m_rt = 0; m_bt = 0;
                end
                2: if (bus.StopReq) begin
                    m_st = 1; m_used = 0;
                end else if (bus.SnoozeReq && m_used < SX) begin
                    m_st = 3; m_used++; m_snt = 0;
                end else if (tick) begin
                    m_rt++;
                    if (m_rt == RS) begin m_st = 1; m_used = 0; end
                end
                default: if (bus.StopReq) begin
                    m_st = 1; m_used = 0;
                end else if (tick) begin
                    m_snt++;
                    if (m_snt == SM * 60) begin
                        m_st = 2; m_rt = 0; m_bt = 0;
                    end
                end
            endcase
        end
        on = bus.Arm;
        exp_v = {on && os == 2, on && os == 2 && (m_bt % 2 == 0),
                 on && os != 0, on && os == 3, 5'(m_ah), 6'(m_am)};
    endtask

    // One clock: drive time, strobe at phase 9, advance wall clock.
    task automatic cyc();
        bus.SecTick = (phase == 9);
        bus.Hour    = 5'(th);
        bus.Minute  = 6'(tm);
        bus.Second  = 6'(ts);
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (bus.SecTick) begin
            ts++;
            if (ts == 60) begin
                ts = 0; tm++;
                if (tm == 60) begin tm = 0; th = (th + 1) % 24; end
            end
        end
        phase = (phase + 1) % 10;
        bus.SetLoad = 1'b0;
        bus.SnoozeReq = 1'b0;
        bus.StopReq = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        th = h; tm = m; ts = s;
    endtask

    // Load an alarm one minute ahead, jump to :58 and wait for Ring.
    task automatic ring_up(input string tag);
        int nh, nm, k;
        nm = tm + 1; nh = th;
        if (nm == 60) begin nm = 0; nh = (th + 1) % 24; end
        bus.SetHour = 5'(nh); bus.SetMin = 6'(nm); bus.SetLoad = 1'b1;
        ts = 58;
        k = 0;
        do begin
            cyc(); k++; n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL %s up: got %h want %h", tag, obs, exp_v);
            end
        end while (bus.Ring !== 1'b1 && k < 80);
        n_vec++;
        if (bus.Ring !== 1'b1) begin
            n_err++;
            $display("FAIL %s ring timeout: Ring=%b want 1", tag, bus.Ring);
        end
    endtask

    // Wait for snooze expiry; returns strobes seen.
    task automatic wait_ring(input string tag, output int nt);
        int k;
        k = 0; nt = 0;
        do begin
            cyc(); k++; n_vec++;
            if (bus.SecTick) nt++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL %s snz: got %h want %h", tag, obs, exp_v);
            end
        end while (bus.Ring !== 1'b1 && k < 700);
        n_vec++;
        if (bus.Ring !== 1'b1) begin
            n_err++;
            $display("FAIL %s snooze timeout: Ring=%b want 1", tag, bus.Ring);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) begin
            cyc(); n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL reset: got %h want %h", obs, exp_v);
            end
        end
        n_vec++;
        if (obs !== 15'd0) begin
            n_err++;
            $display("FAIL reset values: got %h want 0", obs);
        end
        Reset = 1'b0;
    endtask

    task automatic test_ring_basic();
        int k, tog;
        logic prev;
        bus.Arm = 1'b1;
        bus.SetHour = 5'd7; bus.SetMin = 6'd30; bus.SetLoad = 1'b1;
        set_time(7, 29, 58);
        k = 0;
        do begin
            cyc(); k++; n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL basic: got %h want %h", obs, exp_v);
            end
            if (tm == 29 && ts == 59) begin
                n_vec++;
                if (bus.Ring !== 1'b0) begin
                    n_err++;
                    $display("FAIL early ring: Ring=%b want 0", bus.Ring);
                end
            end
        end while (!(tm == 30 && ts == 0) && k < 40);
        cyc(); n_vec++;
        if (bus.Ring !== 1'b0) begin
            n_err++;
            $display("FAIL ring+1: Ring=%b want 0", bus.Ring);
        end
        cyc(); n_vec++;
        if ({bus.Ring, bus.LedBlink} !== 2'b11) begin
            n_err++;
            $display("FAIL ring+2: Ring,Blink=%b want 11",
                     {bus.Ring, bus.LedBlink});
        end
        tog = 0; prev = bus.LedBlink;
        repeat (45) begin
            cyc(); n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL basic ring: got %h want %h", obs, exp_v);
            end
            if (bus.Ring === 1'b1 && bus.LedBlink !== prev) tog++;
            prev = bus.LedBlink;
        end
        n_vec++;
        if (tog != RS || bus.Ring !== 1'b0 || bus.Armed !== 1'b1) begin
            n_err++;
            $display("FAIL timeout: toggles=%0d Ring=%b Armed=%b want %0d 0 1",
                     tog, bus.Ring, bus.Armed, RS);
        end
    endtask

    task automatic test_snooze();
        int nt;
        ring_up("snz");
        for (int i = 0; i < SX; i++) begin
            bus.SnoozeReq = 1'b1;
            repeat (2) cyc();
            n_vec++;
            if ({bus.Snoozing, bus.Ring} !== 2'b10) begin
                n_err++;
                $display("FAIL snooze %0d: Snz,Ring=%b want 10", i,
                         {bus.Snoozing, bus.Ring});
            end
            wait_ring("snz", nt);
            n_vec++;
            if (nt != SM * 60) begin
                n_err++;
                $display("FAIL snooze len: ticks=%0d want %0d", nt, SM * 60);
            end
        end
        bus.SnoozeReq = 1'b1;
        repeat (2) cyc();
        n_vec++;
        if ({bus.Snoozing, bus.Ring} !== 2'b01) begin
            n_err++;
            $display("FAIL snooze limit: Snz,Ring=%b want 01",
                     {bus.Snoozing, bus.Ring});
        end
        repeat (50) begin
            cyc(); n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL snz tail: got %h want %h", obs, exp_v);
            end
        end
    endtask

    task automatic test_stop_snooze();
        int nt;
        ring_up("stop");
        bus.SnoozeReq = 1'b1; bus.StopReq = 1'b1;
        repeat (2) cyc();
        n_vec++;
        if ({bus.Armed, bus.Snoozing, bus.Ring} !== 3'b100) begin
            n_err++;
            $display("FAIL stop wins: A,S,R=%b want 100",
                     {bus.Armed, bus.Snoozing, bus.Ring});
        end
        ring_up("stop2");
        bus.SnoozeReq = 1'b1;
        repeat (2) cyc();
        wait_ring("stop2", nt);
        bus.SnoozeReq = 1'b1;
        repeat (2) cyc();
        n_vec++;
        if (bus.Snoozing !== 1'b1) begin
            n_err++;
            $display("FAIL snooze renew: Snoozing=%b want 1", bus.Snoozing);
        end
        bus.StopReq = 1'b1;
        repeat (2) cyc();
        n_vec++;
        if ({bus.Armed, bus.Snoozing, bus.Ring} !== 3'b100) begin
            n_err++;
            $display("FAIL stop snooze: A,S,R=%b want 100",
                     {bus.Armed, bus.Snoozing, bus.Ring});
        end
    endtask

    task automatic test_arm_window();
        bus.Arm = 1'b0;
        bus.SetHour = 5'd7; bus.SetMin = 6'd30; bus.SetLoad = 1'b1;
        set_time(7, 30, 0);
        repeat (3) cyc();
        bus.Arm = 1'b1;
        repeat (20) begin
            cyc(); n_vec++;
            if (obs !== exp_v || bus.Ring !== 1'b0) begin
                n_err++;
                $display("FAIL late arm: got %h want %h", obs, exp_v);
            end
        end
        set_time(7, 29, 58);
        repeat (40) begin
            cyc(); n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL next day: got %h want %h", obs, exp_v);
            end
        end
        n_vec++;
        if (bus.Ring !== 1'b1) begin
            n_err++;
            $display("FAIL next day ring: Ring=%b want 1", bus.Ring);
        end
        bus.StopReq = 1'b1;
        repeat (2) cyc();
    endtask

    task automatic test_load();
        int h, m;
        bus.SetHour = 5'd24; bus.SetMin = 6'd10; bus.SetLoad = 1'b1;
        cyc();
        bus.SetHour = 5'd12; bus.SetMin = 6'd60; bus.SetLoad = 1'b1;
        cyc(); n_vec++;
        if ({bus.AlarmHour, bus.AlarmMin} !== {5'd7, 6'd30}) begin
            n_err++;
            $display("FAIL bad load: got %0d:%0d want 7:30",
                     bus.AlarmHour, bus.AlarmMin);
        end
        set_time(12, 0, 30);
        repeat (4) begin
            h = $urandom_range(24, 31);
            m = $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) begin
                h = $urandom_range(0, 23);
                m = $urandom_range(60, 63);
            end
            bus.SetHour = 5'(h); bus.SetMin = 6'(m); bus.SetLoad = 1'b1;
            cyc(); n_vec++;
            if (obs !== exp_v || bus.AlarmHour !== 5'd7) begin
                n_err++;
                $display("FAIL rand bad load %0d:%0d: got %h want %h",
                         h, m, obs, exp_v);
            end
        end
        bus.SetHour = 5'd23; bus.SetMin = 6'd59; bus.SetLoad = 1'b1;
        cyc(); n_vec++;
        if (obs !== {4'b0010, 5'd23, 6'd59}) begin
            n_err++;
            $display("FAIL load 23:59: got %h want %h", obs,
                     {4'b0010, 5'd23, 6'd59});
        end
        repeat (6) begin
            h = $urandom_range(0, 23);
            m = $urandom_range(0, 59);
            bus.SetHour = 5'(h); bus.SetMin = 6'(m); bus.SetLoad = 1'b1;
            cyc(); n_vec++;
            if (obs !== exp_v || bus.AlarmMin !== 6'(m)) begin
                n_err++;
                $display("FAIL rand load %0d:%0d: got %h want %h",
                         h, m, obs, exp_v);
            end
        end
    endtask

    task automatic test_abort();
        ring_up("abort");
        bus.SnoozeReq = 1'b1;
        repeat (2) cyc();
        bus.Arm = 1'b0;
        cyc(); n_vec++;
        if (obs[14:11] !== 4'b0 || obs !== exp_v) begin
            n_err++;
            $display("FAIL disarm: got %h want %h", obs, exp_v);
        end
        bus.Arm = 1'b1;
        repeat (2) cyc();
        ring_up("rst");
        Reset = 1'b1;
        set_time(0, 0, 0);
        cyc(); n_vec++;
        if (obs !== 15'd0) begin
            n_err++;
            $display("FAIL reset mid-ring: got %h want 0", obs);
        end
        cyc();
        Reset = 1'b0;
        repeat (40) begin
            cyc(); n_vec++;
            if (obs !== exp_v || bus.Ring !== 1'b0) begin
                n_err++;
                $display("FAIL reset release: got %h want %h", obs, exp_v);
            end
        end
        n_vec++;
        if (bus.Armed !== 1'b1) begin
            n_err++;
            $display("FAIL rearm after reset: Armed=%b want 1", bus.Armed);
        end
    endtask

    task automatic test_random();
        int r, nh, nm;
        for (int i = 0; i < 1500; i++) begin
            if (i % 150 == 0) begin
                nm = tm + 1; nh = th;
                if (nm == 60) begin nm = 0; nh = (th + 1) % 24; end
                bus.SetHour = 5'(nh); bus.SetMin = 6'(nm);
                bus.SetLoad = 1'b1;
                ts = 58;
            end
            r = $urandom_range(0, 99);
            bus.SnoozeReq = (r < 3);
            bus.StopReq = (r == 3);
            bus.Arm = ($urandom_range(0, 199) != 0);
            cyc(); n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL random %0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1;
        bus.SecTick = 1'b0; bus.Hour = '0; bus.Minute = '0;
        bus.Second = '0; bus.SetHour = '0; bus.SetMin = '0;
        bus.SetLoad = 1'b0; bus.Arm = 1'b0;
        bus.SnoozeReq = 1'b0; bus.StopReq = 1'b0;
        @(negedge clk);
        test_reset();
        test_ring_basic();
        test_snooze();
        test_stop_snooze();
        test_arm_window();
        test_load();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
